// File: rtl/acc_dot_accum_pkg.sv
// acc_pkg: shared lane constants, FSM state encoding and the product-vector
// type used by the dot-product accumulator and its lane adder.
package acc_pkg;

    localparam int ACC_LANES  = 4;
    localparam int ACC_PROD_W = 16;
    localparam int ACC_SUM_W  = 18;   // four 16-bit lanes need 2 growth bits

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } acc_dot_state_t;

    // lane0 occupies bits [15:0]
    typedef logic [ACC_LANES-1:0][ACC_PROD_W-1:0] acc_prod_vec_t;

    // Zero-extended sum of all lanes; cannot overflow ACC_SUM_W bits.
    function automatic logic [ACC_SUM_W-1:0] lane_total(input acc_prod_vec_t vec);
        logic [ACC_SUM_W-1:0] total;
        total = '0;
        for (int i = 0; i < ACC_LANES; i++) begin
            total = total + ACC_SUM_W'(vec[i]);
        end
        return total;
    endfunction

endpackage

// File: rtl/acc_dot_accum_if.sv
// acc_dot_accum_if: control, product-stream and result handshake signals of
// the dot-product accumulator. slave = accumulator view, master = driver view.
interface acc_dot_accum_if #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) ();
    import acc_pkg::*;

    logic                start_i;
    logic [LEN_W-1:0]    len_i;
    acc_prod_vec_t       prod_i;
    logic                prod_valid_i;
    logic                prod_ready_o;
    logic [ACC_W-1:0]    res_o;
    logic                res_valid_o;
    logic                res_ready_i;
    logic                busy_o;
    logic                overflow_o;

    modport slave (
        input  start_i, len_i, prod_i, prod_valid_i, res_ready_i,
        output prod_ready_o, res_o, res_valid_o, busy_o, overflow_o
    );

    modport master (
        output start_i, len_i, prod_i, prod_valid_i, res_ready_i,
        input  prod_ready_o, res_o, res_valid_o, busy_o, overflow_o
    );

endinterface

// File: rtl/acc_dot_accum_lane_sum.sv
// acc_lane_sum: stage 1 of the accumulator pipeline. Registers the
// zero-extended sum of the four lane products together with a valid bit.
module acc_lane_sum
    import acc_pkg::*;
(
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 in_valid,
    input  acc_prod_vec_t        in_vec,
    output logic                 sum_valid,
    output logic [ACC_SUM_W-1:0] sum
);

    // Valid bit of the stage: cleared by reset, follows the accepted beat.
    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!HRESETn) begin
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= in_valid;
        end
    end

    // Sum register: loads only on an accepted beat.
    always_ff @(posedge HCLK) begin
        // NOTE: the data register is deliberately left out of reset; it is
        // only ever consumed when sum_valid is set, so its reset value is moot.
        if (in_valid) begin
            sum <= lane_total(in_vec);
        end
    end

endmodule

// File: rtl/acc_dot_accum.sv
// acc_dot_accum: sums the four lane products of each beat (stage 1), adds the
// per-beat sums into an ACC_W accumulator (stage 2) over a programmed number
// of beats and presents the result on a valid/ready handshake.
// Build option: define ACC_SAT_EN to saturate the accumulator at 2^ACC_W-1
// on overflow instead of wrapping modulo 2^ACC_W.
module acc_dot_accum
    import acc_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    acc_dot_accum_if.slave        bus
);

    acc_dot_state_t          state;
    logic [LEN_W-1:0]        remaining;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    logic [ACC_W:0]          sum_wide;
    logic                    carry;

    logic                    ready;
    logic                    res_valid;
    logic                    busy;
    logic                    overflow;
    logic [ACC_W-1:0]        res;

    logic                    beat_accept;
    logic                    s1_valid;
    logic [ACC_SUM_W-1:0]    s1_sum;

    assign beat_accept = bus.prod_valid_i && ready;

    acc_lane_sum u_lane_sum (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .in_valid  (beat_accept),
        .in_vec    (bus.prod_i),
        .sum_valid (s1_valid),
        .sum       (s1_sum)
    );

    // Stage 2 adder: next accumulator value and carry out of ACC_W.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        acc_next = acc;
        carry    = 1'b0;
        sum_wide = {1'b0, acc} + (ACC_W + 1)'(s1_sum);
        if (s1_valid) begin
            carry = sum_wide[ACC_W];
`ifdef ACC_SAT_EN
            acc_next = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
            acc_next = sum_wide[ACC_W-1:0];
`endif
        end
    end

    // Control FSM with registered outputs, beat counter and accumulator.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= IDLE;
            remaining <= '0;
            acc       <= '0;
            ready     <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            res       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (bus.len_i != '0) begin
                            remaining <= bus.len_i;
                            ready     <= 1'b1;
                            state     <= ACCUM;
                        end else begin
                            res       <= '0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end

                ACCUM: begin
                    acc <= acc_next;
                    if (carry) begin
                        overflow <= 1'b1;
                    end
                    if (beat_accept) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            ready <= 1'b0;
                        end
                    end
                    // With no beats left, the last stage-1 sum drains into
                    // acc_next on this edge, so the result is final here.
                    if (remaining == '0) begin
                        res       <= acc_next;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (bus.res_ready_i) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.prod_ready_o = ready;
    assign bus.res_o        = res;
    assign bus.res_valid_o  = res_valid;
    assign bus.busy_o       = busy;
    assign bus.overflow_o   = overflow;

endmodule

// File: doc/acc_dot_accum.md
Name: acc_dot_accum

Overview:
- Downstream consumer of the 4-lane 16-bit product vector produced by the accelerator core.
- Sums the four lane products of each beat through a registered adder stage, then accumulates the per-beat sums over a programmed number of beats into a dot-product result.
- Result is presented on a valid/ready handshake for the APB wrapper to read back.
- Sits between the accelerator core output and the APB register file, in the HCLK domain.

Parameters:
- ACC_W, 32, accumulator and result width in bits; minimum 18.
- LEN_W, 8, width of the beat-count field; maximum run is 2^LEN_W-1 beats.

Ports:
- HCLK  input  1  clock; all state updates on posedge.
- HRESETn  input  1  reset, synchronous, active-low.
- start_i  input  1  start pulse; honoured only in IDLE.
- len_i  input  LEN_W  number of beats in the run; sampled when start is accepted.
- prod_i  input  4x16  lane products, lane0 in bits [15:0]; unsigned.
- prod_valid_i  input  1  prod_i is valid this cycle.
- prod_ready_o  output  1  block accepts prod_i this cycle.
- res_o  output  ACC_W  accumulated result.
- res_valid_o  output  1  res_o is valid.
- res_ready_i  input  1  consumer takes res_o.
- busy_o  output  1  high in any state other than IDLE.
- overflow_o  output  1  sticky flag: accumulator exceeded ACC_W bits during the current run.

Behaviour:
- Reset: when HRESETn=0 at a posedge, all state clears:
  - FSM goes to IDLE.
  - res_o=0, res_valid_o=0, prod_ready_o=0, busy_o=0, overflow_o=0.
  - Beat counter and pipeline valid are cleared.
  - Reset mid-run abandons the run; no partial result is produced.
- State IDLE:
  - On start_i=1 with len_i>0: latch len_i into the remaining-beat counter, clear the accumulator and overflow_o, go to ACCUM.
  - On start_i=1 with len_i=0: go directly to DONE with res_o=0.
- State ACCUM:
  - prod_ready_o=1 while remaining>0; it is a registered-state decode, not combinational on prod_valid_i.
  - A beat is accepted when prod_valid_i && prod_ready_o; on acceptance remaining decrements.
  - Stage 1 registers the sum of the four lanes, 18 bits wide with zero extension.
  - Stage 2 adds the stage-1 sum into the ACC_W accumulator.
  - When remaining reaches 0 and the stage-1 pipeline is empty, go to DONE.
- Latency: the last beat accepted at cycle t gives res_valid_o=1 at cycle t+2.
- State DONE:
  - res_valid_o=1; res_o is held stable until res_valid_o && res_ready_i.
  - After that handshake, go to IDLE.
  - start_i in the handshake cycle is ignored; start is only honoured in IDLE on a later cycle.
- start_i while in ACCUM or DONE is ignored; len_i is not re-sampled.
- Back-to-back beats on consecutive cycles are supported with no bubbles.
- Overflow:
  - A carry out of ACC_W sets overflow_o, which stays set until the next accepted start or reset.
  - Without ACC_SAT_EN the accumulator wraps modulo 2^ACC_W.
- Gaps: prod_valid_i low in ACCUM stalls the run; no timeout.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: the accumulator saturates at 2^ACC_W-1 on overflow and stays saturated for the rest of the run. overflow_o is still set.
- Undefined: wrap-around arithmetic, and no saturation comparator is instantiated.

Decomposition:
- Package acc_pkg:
  - Lane constants: ACC_LANES=4, ACC_PROD_W=16, ACC_SUM_W=18.
  - FSM enum acc_dot_state_t {IDLE, ACCUM, DONE}.
  - Lane vector typedef acc_prod_vec_t (logic [3:0][15:0]).
- Sub-module acc_lane_sum: the registered 4-input adder (stage 1), with valid passthrough.

Test Plan:
- Basic run: len=3, three back-to-back beats with every lane=0x0100 -> res_o=0xC00, res_valid_o 2 cycles after the third accept, overflow_o=0.
- Stall and backpressure: len=2 with a 5-cycle prod_valid_i gap between beats, and res_ready_i held low for 4 cycles -> res_o=(sum of both beats) held stable for all 4 cycles; IDLE entered only after the handshake.
- Zero length: start with len=0 -> next cycle res_valid_o=1, res_o=0, prod_ready_o stays 0.
- Overflow with ACC_W=20, five beats of all lanes=0xFFFF (per-beat sum 262140):
  - Without ACC_SAT_EN -> res_o=262124, overflow_o=1.
  - With ACC_SAT_EN -> res_o=0xFFFFF, overflow_o=1.
- Reset mid-run: HRESETn low for 1 cycle after the 2nd of 4 beats -> all outputs 0, FSM IDLE; a new run with len=1, lanes=1,2,3,4 -> res_o=10.
- Ignored start: pulse start_i during ACCUM with a different len_i -> beat count unchanged, result matches the original len.
